// File: rtl/store_field.sv
// store_field: field-merge store unit for the ST-class commands.
// Reads the target word, overwrites bytes L..R (and the sign when L=0) with the
// rightmost bytes of the register word, and writes the merged word back.
module store_field #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        field,
    input  logic [30:0]       data,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [30:0]       mem_rdata,
    output logic              mem_wr,
    output logic [30:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapt,
        StWrite,
        StDone
    } state_e;

    state_e      state_q;
    logic [5:0]  field_q;
    logic [30:0] data_q;
    logic [30:0] merged;
    logic        field_ok;

    // Field check on the live input: L must not exceed R, and R must be a real byte.
    always_comb begin
        field_ok = (field[5:3] <= field[2:0]) && (field[2:0] <= 3'd5);
    end

    // Merge memory word with the latched register; byte k takes register byte k+5-R.
    always_comb begin
        logic [2:0] l;
        logic [2:0] r;
        logic [2:0] b;
        int         src;
        l      = field_q[5:3];
        r      = field_q[2:0];
        b      = (l == 3'd0) ? 3'd1 : l;
        merged = mem_rdata;
        src    = 0;
        if (l == 3'd0) begin
            merged[30] = data_q[30];
        end
        for (int k = 1; k <= 5; k++) begin
            if ((k >= int'(b)) && (k <= int'(r))) begin
                src = k + 5 - int'(r);
                merged[35-6*k -: 6] = data_q[35-6*src -: 6];
            end
        end
    end

    // Sequencer; every output is registered and updated on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            field_q   <= '0;
            data_q    <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        field_q <= field;
                        data_q  <= data;
                        busy    <= 1'b1;
                        if (field_ok) begin
                            err      <= 1'b0;
                            mem_addr <= addr;
                            mem_rd   <= 1'b1;
                            state_q  <= StRead;
                        end else begin
                            // Bad field: complete immediately without touching memory.
                            err     <= 1'b1;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StRead: begin
                    mem_rd  <= 1'b0;
                    state_q <= StCapt;
                end
                StCapt: begin
                    // Read data is valid now; fold it straight into the write register.
                    mem_wdata <= merged;
                    mem_wr    <= 1'b1;
                    state_q   <= StWrite;
                end
                StWrite: begin
                    mem_wr  <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_field.sv
// tb_store_field: directed checks of the store_field merge, timing and control.
module tb_store_field;

    localparam int unsigned AW = 12;
    localparam logic [AW-1:0] M = 12'd2000;
    // Memory word "- 1 2 3 4 5" and register "+ 6 7 8 9 0".
    localparam logic [30:0] MEMW = {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
    localparam logic [30:0] REGW = {1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [5:0]    field;
    logic [30:0]   data;
    logic [AW-1:0] addr;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [30:0]   mem_rdata = '0;
    logic          mem_wr;
    logic [30:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;

    store_field #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .field     (field),
        .data      (data),
        .addr      (addr),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory: one populated word, read data one cycle after mem_rd, writes counted.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= (mem_addr == M) ? MEMW : 31'h0;
        if (mem_wr) wr_count <= wr_count + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; field = '0; data = '0; addr = '0;
        #12;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            fails++;
            $display("FAIL reset: ctl=%b addr=%0d wdata=%h, want ctl=00000 addr=0 wdata=0",
                     {mem_rd, mem_wr, busy, done, err}, mem_addr, mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store(input string nm, input logic [5:0] f, input logic [30:0] exp);
        int w0;
        @(negedge clk);
        start = 1'b1; field = f; data = REGW; addr = M; w0 = wr_count;
        @(posedge clk); #1;
        // Inputs change after acceptance; the latched copies must be used.
        start = 1'b0; field = 6'd0; data = '1; addr = 12'd7;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b10100 || mem_addr !== M) begin
            fails++;
            $display("FAIL %s c1: ctl=%b addr=%0d, want ctl=10100 addr=%0d",
                     nm, {mem_rd, mem_wr, busy, done, err}, mem_addr, M);
        end
        @(posedge clk); #1;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b00100) begin
            fails++;
            $display("FAIL %s c2: ctl=%b, want 00100", nm, {mem_rd, mem_wr, busy, done, err});
        end
        @(posedge clk); #1;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b01100 || mem_wdata !== exp || mem_addr !== M) begin
            fails++;
            $display("FAIL %s c3: ctl=%b wdata=%h addr=%0d, want ctl=01100 wdata=%h addr=%0d",
                     nm, {mem_rd, mem_wr, busy, done, err}, mem_wdata, mem_addr, exp, M);
        end
        @(posedge clk); #1;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b00110) begin
            fails++;
            $display("FAIL %s c4: ctl=%b, want 00110", nm, {mem_rd, mem_wr, busy, done, err});
        end
        @(posedge clk); #1;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b00000 || wr_count - w0 !== 1) begin
            fails++;
            $display("FAIL %s c5: ctl=%b writes=%0d, want ctl=00000 writes=1",
                     nm, {mem_rd, mem_wr, busy, done, err}, wr_count - w0);
        end
    endtask

    task automatic test_invalid(input string nm, input logic [5:0] f);
        int w0;
        @(negedge clk);
        start = 1'b1; field = f; data = REGW; addr = M; w0 = wr_count;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b00111) begin
            fails++;
            $display("FAIL %s c1: ctl=%b, want 00111", nm, {mem_rd, mem_wr, busy, done, err});
        end
        @(posedge clk); #1;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b00001 || wr_count != w0) begin
            fails++;
            $display("FAIL %s c2: ctl=%b writes=%0d, want ctl=00001 writes=0",
                     nm, {mem_rd, mem_wr, busy, done, err}, wr_count - w0);
        end
    endtask

    task automatic test_busy_ignore();
        int w0;
        @(negedge clk);
        start = 1'b1; field = 6'd5; data = REGW; addr = M; w0 = wr_count;
        @(posedge clk); #1;
        // Hold start with different operands through cycles 1..3.
        start = 1'b1; field = 6'd0; data = 31'h0; addr = 12'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (mem_wr !== 1'b1 || mem_wdata !== {1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd0} || mem_addr !== M) begin
            fails++;
            $display("FAIL busy_ignore c3: wr=%b wdata=%h addr=%0d, want wr=1 wdata=%h addr=%0d",
                     mem_wr, mem_wdata, mem_addr, {1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd0}, M);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (wr_count - w0 !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore end: writes=%0d busy=%b, want writes=1 busy=0",
                     wr_count - w0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        @(negedge clk);
        start = 1'b1; field = 6'd19; data = REGW; addr = M; w0 = wr_count;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            fails++;
            $display("FAIL reset_mid: ctl=%b addr=%0d wdata=%h, want all zero",
                     {mem_rd, mem_wr, busy, done, err}, mem_addr, mem_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (wr_count != w0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid writes: writes=%0d busy=%b, want writes=0 busy=0",
                     wr_count - w0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_store("f05", 6'd5,  {1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd0});
        test_store("f15", 6'd13, {1'b1, 6'd6, 6'd7, 6'd8, 6'd9, 6'd0});
        test_store("f55", 6'd45, {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0});
        test_store("f22", 6'd18, {1'b1, 6'd1, 6'd0, 6'd3, 6'd4, 6'd5});
        test_store("f23", 6'd19, {1'b1, 6'd1, 6'd9, 6'd0, 6'd4, 6'd5});
        test_store("f01", 6'd1,  {1'b0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5});
        test_store("f00", 6'd0,  {1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5});
        test_invalid("f32", 6'd26);
        test_store("f05_after_err", 6'd5, {1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd0});
        test_invalid("f06", 6'd6);
        test_store("f22_after_err", 6'd18, {1'b1, 6'd1, 6'd0, 6'd3, 6'd4, 6'd5});
        test_busy_ignore();
        test_reset_mid();
        test_store("f23_after_rst", 6'd19, {1'b1, 6'd1, 6'd9, 6'd0, 6'd4, 6'd5});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
